// File: rtl/openofdm_tx_pre_def.sv
// Shared definitions for the openofdm_tx preamble path: sequencer states,
// short-symbol length and packed I/Q field layout.
package openofdm_tx_pre_def;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stf_state_t;

   localparam int unsigned STF_SYM_LEN = 16;

   // Packed sample layout: {I, Q}, each 16-bit two's complement
   localparam int unsigned IQ_W      = 32;
   localparam int unsigned IQ_COMP_W = 16;
   localparam int unsigned IQ_I_MSB  = 31;
   localparam int unsigned IQ_I_LSB  = 16;
   localparam int unsigned IQ_Q_MSB  = 15;
   localparam int unsigned IQ_Q_LSB  = 0;

endpackage

// File: rtl/iq_half_scale.sv
// Halves both components of a packed I/Q sample with a sign-preserving shift.
// Used for first-sample edge windowing of the preamble fields.
module iq_half_scale
   import openofdm_tx_pre_def::*;
(
   input  logic [IQ_W-1:0] i_iq,
   output logic [IQ_W-1:0] o_iq
);

   logic signed [IQ_COMP_W-1:0] w_i;
   logic signed [IQ_COMP_W-1:0] w_q;

   assign w_i  = i_iq[IQ_I_MSB:IQ_I_LSB];
   assign w_q  = i_iq[IQ_Q_MSB:IQ_Q_LSB];
   assign o_iq = {w_i >>> 1, w_q >>> 1};

endmodule

// File: rtl/stf_seq_ctrl.sv
// L-STF sequencer: walks the external 16-entry ROM NUM_REP times and streams
// registered I/Q samples with valid/ready handshake, last marker and done pulse.
module stf_seq_ctrl
   import openofdm_tx_pre_def::*;
#(
   parameter int unsigned NUM_REP   = 10,
   parameter bit          WINDOW_EN = 1'b1
) (
   input  logic        clk,
   input  logic        phy_tx_arestn,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  rom_addr,
   input  logic [31:0] rom_dout,
   output logic [31:0] stf_data,
   output logic        stf_valid,
   input  logic        stf_ready,
   output logic        stf_last,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] LAST_IDX = 8'(STF_SYM_LEN * NUM_REP - 1);

   stf_state_t  r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_data, w_data_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_last, w_last_nxt;
   logic        r_done, w_done_nxt;
   logic        w_ld;
   logic [31:0] w_scaled;
   logic [31:0] w_ld_data;

   iq_half_scale u_half (
      .i_iq (rom_dout),
      .o_iq (w_scaled)
   );

   // Only burst sample 0 is windowed; later repetition starts pass through
   assign w_ld_data = (WINDOW_EN && (r_cnt == '0)) ? w_scaled : rom_dout;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      w_done_nxt  = 1'b0;
      w_ld        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end
         end
         RUN: begin
            w_ld = !r_valid || stf_ready;
            if (w_ld) begin
               w_data_nxt  = w_ld_data;
               w_valid_nxt = 1'b1;
               w_last_nxt  = (r_cnt == LAST_IDX);
               w_cnt_nxt   = r_cnt + 8'd1;
               if (r_cnt == LAST_IDX) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (stf_ready) begin
               w_valid_nxt = 1'b0;
               w_last_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // Abort overrides start and any load in the same cycle
      if (abort) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_valid_nxt = 1'b0;
         w_last_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge phy_tx_arestn) begin
      if (!phy_tx_arestn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign rom_addr  = (r_state == RUN) ? r_cnt[3:0] : '0;
   assign stf_data  = r_data;
   assign stf_valid = r_valid;
   assign stf_last  = r_last;
   assign done      = r_done;
   assign busy      = (r_state == RUN) || (r_state == DRAIN);

endmodule

// File: tb/tb_stf_seq_ctrl.sv
// Self-checking bench for stf_seq_ctrl: two configurations, directed steps
// with randomized backpressure against a sample-index reference model.
module tb_stf_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] rom [16];

   logic        a_start, a_abort, a_ready, a_valid, a_last, a_busy, a_done;
   logic [3:0]  a_addr;
   logic [31:0] a_dout, a_data;
   logic        b_start, b_abort, b_ready, b_valid, b_last, b_busy, b_done;
   logic [3:0]  b_addr;
   logic [31:0] b_dout, b_data;

   assign a_dout = rom[a_addr];
   assign b_dout = rom[b_addr];

   stf_seq_ctrl #(.NUM_REP(10), .WINDOW_EN(1'b1)) u_dut_a (
      .clk(clk), .phy_tx_arestn(rst_n), .start(a_start), .abort(a_abort),
      .rom_addr(a_addr), .rom_dout(a_dout), .stf_data(a_data), .stf_valid(a_valid),
      .stf_ready(a_ready), .stf_last(a_last), .busy(a_busy), .done(a_done)
   );

   stf_seq_ctrl #(.NUM_REP(2), .WINDOW_EN(1'b0)) u_dut_b (
      .clk(clk), .phy_tx_arestn(rst_n), .start(b_start), .abort(b_abort),
      .rom_addr(b_addr), .rom_dout(b_dout), .stf_data(b_data), .stf_valid(b_valid),
      .stf_ready(b_ready), .stf_last(b_last), .busy(b_busy), .done(b_done)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic g_valid(input int inst); return (inst == 0) ? a_valid : b_valid; endfunction
   function automatic logic g_last (input int inst); return (inst == 0) ? a_last  : b_last;  endfunction
   function automatic logic g_busy (input int inst); return (inst == 0) ? a_busy  : b_busy;  endfunction
   function automatic logic g_done (input int inst); return (inst == 0) ? a_done  : b_done;  endfunction
   function automatic logic [31:0] g_data(input int inst); return (inst == 0) ? a_data : b_data; endfunction

   task automatic set_ready(input int inst, input logic v);
      if (inst == 0) a_ready = v; else b_ready = v;
   endtask

   task automatic set_start(input int inst, input logic v);
      if (inst == 0) a_start = v; else b_start = v;
   endtask

   function automatic int half_floor(input int x);
      return (x < 0) ? -((-x + 1) / 2) : x / 2;
   endfunction

   // Burst sample k is ROM[k mod 16]; sample 0 halved when windowing is on
   function automatic logic [31:0] exp_sample(input int k, input bit win);
      logic [31:0] s;
      int iv, qv;
      s = rom[k % 16];
      if (win && k == 0) begin
         iv = half_floor(int'($signed(s[31:16])));
         qv = half_floor(int'($signed(s[15:0])));
         s  = {16'(iv), 16'(qv)};
      end
      return s;
   endfunction

   task automatic kick(input int inst);
      set_start(inst, 1'b1);
      tick();
      set_start(inst, 1'b0);
      chk("kick_busy", g_busy(inst), 1);
      chk("kick_valid_n1", g_valid(inst), 0);
   endtask

   task automatic post_idle(input int inst);
      chk("post_done_low", g_done(inst), 0);
      chk("post_busy_low", g_busy(inst), 0);
      chk("post_valid_low", g_valid(inst), 0);
   endtask

   task automatic run(input int inst, input int nexp, input int duty, input bit win,
                      input int stop_at, input int st1, input int st2);
      int k;
      bit held, fin, r;
      logic [31:0] hd, d;
      logic hl, v, l;
      k = 0; held = 0; fin = 0; hd = '0; hl = 1'b0;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         r = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
         set_ready(inst, r);
         set_start(inst, (k == st1) || (k == st2));
         v = g_valid(inst); d = g_data(inst); l = g_last(inst);
         if (held) begin
            chk("hold_valid", v, 1);
            chk("hold_data", d, hd);
            chk("hold_last", l, hl);
         end
         held = 0;
         if (v && r) begin
            chk($sformatf("data[%0d]", k), d, exp_sample(k, win));
            chk($sformatf("last[%0d]", k), l, (k == nexp - 1));
            k++;
         end else if (v) begin
            held = 1; hd = d; hl = l;
         end
         tick();
         set_start(inst, 1'b0);
         if (k == nexp) begin
            chk("done_pulse", g_done(inst), 1);
            chk("busy_falls_with_done", g_busy(inst), 0);
            fin = 1;
         end else begin
            chk("no_early_done", g_done(inst), 0);
            if (k == stop_at) fin = 1;
         end
      end
      if (!fin) chk("burst_timeout", 0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rom[0]  = 32'h01F6_01F6; rom[1]  = 32'hFA59_001A;
      rom[2]  = 32'hFF72_FCA2; rom[3]  = 32'h0619_FF72;
      rom[4]  = 32'h03EC_0000; rom[5]  = 32'h0619_FF72;
      rom[6]  = 32'hFF72_FCA2; rom[7]  = 32'hFA59_001A;
      rom[8]  = 32'h01F6_01F6; rom[9]  = 32'h001A_FA59;
      rom[10] = 32'hFCA2_FF72; rom[11] = 32'hFF72_0619;
      rom[12] = 32'h0000_03EC; rom[13] = 32'hFF72_0619;
      rom[14] = 32'hFCA2_FF72; rom[15] = 32'h001A_FA59;
      rst_n = 1'b0;
      a_start = 0; a_abort = 0; a_ready = 0;
      b_start = 0; b_abort = 0; b_ready = 0;
      tick(); tick();
      chk("rst_data", a_data, 32'h0);
      chk("rst_valid", a_valid, 0);
      chk("rst_last", a_last, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_addr", a_addr, 0);
      chk("rst_b_valid", b_valid, 0);
      rst_n = 1'b1;
      tick(); tick();
      chk("idle_busy", a_busy, 0);

      // Full burst, ready high, stray starts mid-burst and on the final accept
      a_ready = 1'b1;
      kick(0);
      tick();
      chk("lat_valid_n2", a_valid, 1);
      chk("first_sample_windowed", a_data, 32'h00FB_00FB);
      run(0, 160, 100, 1'b1, -1, 5, 159);
      tick(); post_idle(0);
      tick(); post_idle(0);

      // Unwindowed two-repetition configuration
      b_ready = 1'b1;
      kick(1);
      tick();
      chk("b_first_sample", b_data, 32'h01F6_01F6);
      run(1, 32, 100, 1'b0, -1, -1, -1);
      tick(); post_idle(1);
      b_ready = 1'b0;

      // Asynchronous reset between clock edges in the middle of RUN
      a_ready = 1'b1;
      kick(0);
      repeat (20) tick();
      chk("pre_reset_busy", a_busy, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_data", a_data, 32'h0);
      chk("arst_valid", a_valid, 0);
      chk("arst_last", a_last, 0);
      chk("arst_busy", a_busy, 0);
      chk("arst_done", a_done, 0);
      chk("arst_addr", a_addr, 0);
      #3 rst_n = 1'b1;
      repeat (3) tick();
      post_idle(0);

      // Random ~50% backpressure over a full burst
      kick(0);
      run(0, 160, 50, 1'b1, -1, -1, -1);
      tick(); post_idle(0);

      // Abort with ready low while sample 69 is presented (cnt = 70)
      a_ready = 1'b1;
      kick(0);
      run(0, 160, 100, 1'b1, 69, -1, -1);
      chk("pre_abort_data", a_data, exp_sample(69, 1'b1));
      a_ready = 1'b0;
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      chk("abort_valid", a_valid, 0);
      chk("abort_last", a_last, 0);
      chk("abort_busy", a_busy, 0);
      chk("abort_done", a_done, 0);
      tick(); post_idle(0);

      // start and abort together in IDLE: abort wins
      a_start = 1'b1; a_abort = 1'b1;
      tick();
      a_start = 1'b0; a_abort = 1'b0;
      chk("start_abort_busy", a_busy, 0);
      tick(); post_idle(0);

      // Fresh burst after abort begins at sample 0
      a_ready = 1'b1;
      kick(0);
      tick();
      chk("fresh_first_sample", a_data, 32'h00FB_00FB);
      run(0, 160, 100, 1'b1, -1, -1, -1);
      tick(); post_idle(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
